// File: rtl/elm_ctrl_pkg.sv
// Shared types and default sizing for the ELM layer controller.
package elm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        DONE
    } elm_state_e;

    localparam int ELM_N_IN    = 420;
    localparam int ELM_N_OUT   = 10;
    localparam int ELM_MUL_LAT = 2;

endpackage

// File: rtl/elm_valid_delay.sv
// Fixed-depth valid pipeline that lines the issue strobe up with the
// multiplier output; a flush empties it in one cycle.
module elm_valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] shift_q;
    logic [DEPTH-1:0] shift_d;

    // Next contents: shift one stage per cycle, or empty everything on flush.
    always_comb begin
        shift_d    = '0;
        shift_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
        if (flush) begin
            shift_d = '0;
        end
    end

    // Delay line storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign dout = shift_q[DEPTH-1];

endmodule

// File: rtl/elm_mac_sequencer.sv
// Sequences the serial multiply-accumulate datapath over all neurons of one
// ELM layer: clear, stream address pairs, drain the multiplier, capture.
module elm_mac_sequencer
    import elm_ctrl_pkg::*;
#(
    parameter int N_IN    = ELM_N_IN,
    parameter int N_OUT   = ELM_N_OUT,
    parameter int MUL_LAT = ELM_MUL_LAT,
    localparam int IN_AW  = $clog2(N_IN),
    localparam int W_AW   = $clog2(N_IN * N_OUT),
    localparam int N_AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [IN_AW-1:0] in_addr,
    output logic [W_AW-1:0]  w_addr,
    output logic             issue,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             capture,
    output logic [N_AW-1:0]  neuron_idx
);

    localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    elm_state_e       state_q, state_d;
    logic [IN_AW-1:0] in_addr_q, in_addr_d;
    logic [W_AW-1:0]  w_addr_q, w_addr_d;
    logic [N_AW-1:0]  neuron_idx_q, neuron_idx_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             issue_q, issue_d;
    logic             acc_clr_q, acc_clr_d;
    logic             capture_q, capture_d;
    logic             flush;

    // Next-state and next-output logic; outputs are computed for the state
    // being entered so that every output leaves a flop.
    always_comb begin
        state_d      = state_q;
        in_addr_d    = in_addr_q;
        w_addr_d     = w_addr_q;
        neuron_idx_d = neuron_idx_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issue_d      = 1'b0;
        acc_clr_d    = 1'b0;
        capture_d    = 1'b0;
        flush        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    busy_d    = 1'b1;
                    acc_clr_d = 1'b1;
                    in_addr_d = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                issue_d = 1'b1;
            end
            FEED: begin
                w_addr_d = w_addr_q + W_AW'(1);
                if (in_addr_q == IN_AW'(N_IN - 1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    in_addr_d = in_addr_q + IN_AW'(1);
                    issue_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(MUL_LAT - 1)) begin
                    state_d   = CAPTURE;
                    capture_d = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            CAPTURE: begin
                in_addr_d = '0;
                if (neuron_idx_q == N_AW'(N_OUT - 1)) begin
                    state_d      = DONE;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    neuron_idx_d = '0;
                    w_addr_d     = '0;
                end else begin
                    state_d      = CLEAR;
                    acc_clr_d    = 1'b1;
                    neuron_idx_d = neuron_idx_q + N_AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            in_addr_d    = '0;
            w_addr_d     = '0;
            neuron_idx_d = '0;
            drain_d      = '0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            issue_d      = 1'b0;
            acc_clr_d    = 1'b0;
            capture_d    = 1'b0;
            flush        = 1'b1;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            in_addr_q    <= '0;
            w_addr_q     <= '0;
            neuron_idx_q <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            issue_q      <= 1'b0;
            acc_clr_q    <= 1'b0;
            capture_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_addr_q    <= in_addr_d;
            w_addr_q     <= w_addr_d;
            neuron_idx_q <= neuron_idx_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            issue_q      <= issue_d;
            acc_clr_q    <= acc_clr_d;
            capture_q    <= capture_d;
        end
    end

    elm_valid_delay #(
        .DEPTH(MUL_LAT)
    ) u_valid_delay (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .din  (issue_q),
        .dout (acc_en)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign in_addr    = in_addr_q;
    assign w_addr     = w_addr_q;
    assign issue      = issue_q;
    assign acc_clr    = acc_clr_q;
    assign capture    = capture_q;
    assign neuron_idx = neuron_idx_q;

endmodule

// File: tb/tb_elm_mac_sequencer.sv
// Bench for elm_mac_sequencer: a small configuration checked every cycle
// against a schedule model plus a MAC scoreboard, and the default
// configuration checked for pass totals.
module tb_elm_mac_sequencer;

    localparam int S_IN  = 4;
    localparam int S_OUT = 2;
    localparam int S_LAT = 2;
    localparam int P     = S_IN + S_LAT + 2;
    localparam int NP    = S_OUT * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic big_start = 1'b0;

    logic       busy, done, issue, acc_clr, acc_en, capture;
    logic [1:0] in_addr;
    logic [2:0] w_addr;
    logic [0:0] neuron_idx;

    logic        b_busy, b_done, b_issue, b_acc_clr, b_acc_en, b_capture;
    logic [8:0]  b_in_addr;
    logic [12:0] b_w_addr;
    logic [3:0]  b_neuron_idx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    bit m_active = 1'b0;
    int m_start = 0;

    int in_rom[4] = '{1, 2, 3, 4};
    int w_rom[8]  = '{1, 1, 1, 1, 2, 0, 1, 3};
    int ref_sum[2];
    int acc = 0;
    int p1 = 0;
    int p2 = 0;

    int clr_q[$];
    int cap_q[$];
    int done_q[$];

    always #5 clk = ~clk;

    elm_mac_sequencer #(
        .N_IN(S_IN), .N_OUT(S_OUT), .MUL_LAT(S_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .in_addr(in_addr), .w_addr(w_addr),
        .issue(issue), .acc_clr(acc_clr), .acc_en(acc_en),
        .capture(capture), .neuron_idx(neuron_idx)
    );

    elm_mac_sequencer dut_big (
        .clk(clk), .rst(rst), .start(big_start), .abort(1'b0),
        .busy(b_busy), .done(b_done), .in_addr(b_in_addr), .w_addr(b_w_addr),
        .issue(b_issue), .acc_clr(b_acc_clr), .acc_en(b_acc_en),
        .capture(b_capture), .neuron_idx(b_neuron_idx)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input int n);
        start = st;
        abort = ab;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic int qat(input int q[$], input int i, input int base);
        if (i < q.size()) return q[i] - base;
        return -1;
    endfunction

    // Pass-level model: a pass is either idle or a known number of cycles
    // past its accepted start.
    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (m_active) begin
            if (abort || (cyc - m_start) == NP + 1) m_active = 1'b0;
        end else if (start) begin
            m_active = 1'b1;
            m_start  = cyc;
        end
        cyc++;
    end

    // Every-cycle comparison of the small DUT against the schedule model,
    // plus a multiplier/accumulator scoreboard fed by the DUT strobes.
    always @(negedge clk) begin
        if (chk_en) begin
            int k, n, r;
            bit e_busy, e_done, e_issue, e_clr, e_en, e_cap;
            e_busy = 0; e_done = 0; e_issue = 0; e_clr = 0; e_en = 0; e_cap = 0;
            n = 0; r = 0;
            if (m_active) begin
                k = cyc - m_start;
                if (k <= NP) begin
                    n = (k - 1) / P;
                    r = (k - 1) % P;
                    e_busy  = 1;
                    e_clr   = (r == 0);
                    e_issue = (r >= 1) && (r <= S_IN);
                    e_en    = (r >= S_LAT + 1) && (r <= S_IN + S_LAT);
                    e_cap   = (r == P - 1);
                end else begin
                    e_done = 1;
                end
            end
            checkOutput($sformatf("busy@%0d", cyc), busy, e_busy);
            checkOutput($sformatf("done@%0d", cyc), done, e_done);
            checkOutput($sformatf("issue@%0d", cyc), issue, e_issue);
            checkOutput($sformatf("acc_clr@%0d", cyc), acc_clr, e_clr);
            checkOutput($sformatf("acc_en@%0d", cyc), acc_en, e_en);
            checkOutput($sformatf("capture@%0d", cyc), capture, e_cap);
            if (e_issue) begin
                checkOutput($sformatf("in_addr@%0d", cyc), in_addr, r - 1);
                checkOutput($sformatf("w_addr@%0d", cyc), w_addr, n * S_IN + r - 1);
            end
            if (e_cap || e_clr) begin
                checkOutput($sformatf("neuron_idx@%0d", cyc), neuron_idx, n);
            end
            if (!m_active) begin
                checkOutput($sformatf("idle_in_addr@%0d", cyc), in_addr, 0);
                checkOutput($sformatf("idle_w_addr@%0d", cyc), w_addr, 0);
                checkOutput($sformatf("idle_neuron_idx@%0d", cyc), neuron_idx, 0);
            end
            checkOutput($sformatf("clr_en_overlap@%0d", cyc), acc_clr & acc_en, 0);

            if (acc_clr) clr_q.push_back(cyc);
            if (done) done_q.push_back(cyc);
            if (capture) begin
                cap_q.push_back(cyc);
                checkOutput($sformatf("capture_sum@%0d", cyc), acc, ref_sum[neuron_idx]);
            end
            if (acc_clr) acc = 0;
            if (acc_en) acc = acc + p2;
            p2 = p1;
            p1 = issue ? in_rom[in_addr] * w_rom[w_addr] : 0;
        end
    end

    initial begin
        int t0, t1;
        int b_issues, b_ens, b_caps, b_max_w, b_done_at;
        bit b_seen;

        for (int n = 0; n < S_OUT; n++) begin
            ref_sum[n] = 0;
            for (int i = 0; i < S_IN; i++) ref_sum[n] += in_rom[i] * w_rom[n * S_IN + i];
        end
        checkOutput("ref_sum0", ref_sum[0], 10);
        checkOutput("ref_sum1", ref_sum[1], 17);

        // Reset then idle
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 0, 6);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_issue", issue, 0);

        // Single pass
        clr_q.delete(); cap_q.delete(); done_q.delete();
        t0 = cyc;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 22);
        checkOutput("pass_clr0", qat(clr_q, 0, t0), 1);
        checkOutput("pass_clr1", qat(clr_q, 1, t0), 9);
        checkOutput("pass_cap0", qat(cap_q, 0, t0), 8);
        checkOutput("pass_cap1", qat(cap_q, 1, t0), 16);
        checkOutput("pass_done", qat(done_q, 0, t0), 17);
        checkOutput("pass_done_count", done_q.size(), 1);

        // Abort in the feed phase of neuron 1
        clr_q.delete(); cap_q.delete(); done_q.delete();
        t0 = cyc;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 11);
        applyStimulus(0, 1, 1);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_acc_en", acc_en, 0);
        applyStimulus(0, 0, 12);
        checkOutput("abort_caps", cap_q.size(), 1);
        checkOutput("abort_dones", done_q.size(), 0);
        t1 = cyc;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        checkOutput("restart_issue", issue, 1);
        checkOutput("restart_w_addr", w_addr, 0);
        checkOutput("restart_neuron", neuron_idx, 0);
        applyStimulus(0, 0, 20);
        checkOutput("restart_done", done_q.size() == 1 ? done_q[0] - t1 : -1, 17);

        // Start while busy, with abort alongside the accepted start
        clr_q.delete(); cap_q.delete(); done_q.delete();
        t0 = cyc;
        applyStimulus(1, 1, 1);
        applyStimulus(0, 0, 4);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 11);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 6);
        checkOutput("busy_start_dones", done_q.size(), 1);
        checkOutput("busy_start_done_at", qat(done_q, 0, t0), 17);
        checkOutput("busy_start_clrs", clr_q.size(), 2);

        // Start held high: back-to-back passes
        clr_q.delete(); cap_q.delete(); done_q.delete();
        t0 = cyc;
        applyStimulus(1, 0, 30);
        applyStimulus(0, 0, 10);
        checkOutput("held_clr2", qat(clr_q, 2, t0), 19);
        checkOutput("held_done1", qat(done_q, 1, t0), 35);
        checkOutput("held_dones", done_q.size(), 2);

        // Reset in the middle of a pass
        t0 = cyc;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rst_issue", issue, 0);
        checkOutput("rst_busy", busy, 0);
        applyStimulus(0, 0, 12);

        // Default configuration, full pass
        b_issues = 0; b_ens = 0; b_caps = 0; b_max_w = 0; b_done_at = -1; b_seen = 0;
        t0 = cyc;
        big_start = 1'b1;
        @(posedge clk); #1;
        big_start = 1'b0;
        for (int i = 0; i < 4400 && !b_seen; i++) begin
            @(negedge clk);
            if (b_issue) begin
                b_issues++;
                if (int'(b_w_addr) > b_max_w) b_max_w = int'(b_w_addr);
            end
            if (b_acc_en) b_ens++;
            if (b_capture) b_caps++;
            if (b_done) begin
                b_seen = 1;
                b_done_at = cyc - t0;
            end
        end
        checkOutput("big_done_at", b_done_at, 4241);
        checkOutput("big_issues", b_issues, 4200);
        checkOutput("big_acc_en", b_ens, 4200);
        checkOutput("big_captures", b_caps, 10);
        checkOutput("big_max_w_addr", b_max_w, 4199);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("big_idle_busy", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
